// File: rtl/add_sched_pkg.sv
// Shared definitions for the serial-adder scheduler: FSM state encoding and default sizes.
package add_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial ripple adder datapath: operands shift out LSB-first, sum shifts in at the MSB.
// Final-carry register present only when ADD_SERIAL_SCHED_COUT_EN is defined.
module serial_add_core
    import add_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_i,
    input  logic                       step_i,
    input  logic                       last_i,
    input  logic [WIDTH-1:0]           a_i,
    input  logic [WIDTH-1:0]           b_i,
    output logic [$clog2(WIDTH)-1:0]   cnt_o,
`ifdef ADD_SERIAL_SCHED_COUT_EN
    output logic                       cout_o,
`endif
    output logic [WIDTH-1:0]           sum_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             sum_bit, carry_d;

    assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (step_i) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
            carry_q <= carry_d;
            cnt_q   <= last_i ? '0 : cnt_q + 1'b1;
        end
    end

`ifdef ADD_SERIAL_SCHED_COUT_EN
    logic cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_q <= 1'b0;
        end else if (load_i) begin
            cout_q <= 1'b0;
        end else if (step_i && last_i) begin
            cout_q <= carry_d;
        end
    end

    assign cout_o = cout_q;
`endif

    assign cnt_o = cnt_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/add_serial_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
// Define ADD_SERIAL_SCHED_COUT_EN to expose the final carry on res_cout.
module add_serial_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
`ifdef ADD_SERIAL_SCHED_COUT_EN
    output logic                      res_cout,
`endif
    output logic [WIDTH-1:0]          res_sum,
    output logic [$clog2(NREQ)-1:0]   res_id
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    state_t           state_q;
    logic [IDW-1:0]   last_id_q, res_id_q;
    logic [IDW-1:0]   win_id, idx;
    logic             win_found;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             load, step, last;
    logic [CW-1:0]    cnt;

    // Search starts one past the last served requester, giving strict rotation.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last_id_q) + k) % NREQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_id) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load = (state_q == IDLE) && win_found;
    assign step = (state_q == ADD);
    assign last = step && (cnt == CW'(WIDTH - 1));

    // gnt marks the capture cycle itself, so it is decoded from IDLE and masked by reset.
    always_comb begin
        gnt = '0;
        if (load && !rst) gnt[win_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_id_q <= IDW'(NREQ - 1);
            res_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (win_found) begin
                    state_q  <= ADD;
                    res_id_q <= win_id;
                end
                ADD: if (last) state_q <= DONE;
                DONE: if (res_ready) begin
                    last_id_q <= res_id_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    serial_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .last_i (last),
        .a_i    (a_sel),
        .b_i    (b_sel),
        .cnt_o  (cnt),
`ifdef ADD_SERIAL_SCHED_COUT_EN
        .cout_o (res_cout),
`endif
        .sum_o  (res_sum)
    );

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign res_id    = res_id_q;

endmodule

// File: doc/add_serial_sched.md
ADD_SERIAL_SCHED -- requirements
Module: add_serial_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the serial adder (2..8).
REQ-002 Parameter WIDTH, default 8: operand and result width in bits (2..16).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester operation request, level; held until matching gnt bit.
REQ-006 a_in  input  NREQ*WIDTH  operand A per requester; slice i = requester i.
REQ-007 b_in  input  NREQ*WIDTH  operand B per requester; slice i = requester i.
REQ-008 gnt  output  NREQ  one-hot, one-cycle pulse: operands of that requester captured this cycle.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-012 res_sum  output  WIDTH  sum of captured A and B, modulo 2^WIDTH.
REQ-013 res_id  output  clog2(NREQ)  index of requester owning res_sum.
REQ-014 res_cout  output  1  final carry out; present only with the configuration macro.

Function
REQ-015 FSM states SHALL be IDLE, ADD, DONE.
REQ-016 IDLE: if any req bit set, select winner round-robin starting at (last_id+1) mod NREQ, pulse gnt[winner], capture a_in/b_in slices and winner id, clear carry and bit counter, go ADD next cycle.
REQ-017 IDLE with no req: stay IDLE, gnt all zero.
REQ-018 ADD: each cycle compute sum bit = a0^b0^carry and carry = majority(a0,b0,carry) on current LSBs; shift A and B right by one; shift sum bit into res_sum MSB (result LSB-first); increment counter.
REQ-019 ADD SHALL last exactly WIDTH cycles; on counter==WIDTH-1 go DONE.
REQ-020 DONE: res_valid high, res_sum/res_id/res_cout stable; on res_valid&&res_ready set last_id=res_id and go IDLE; otherwise hold.
REQ-021 Latency: gnt cycle to first res_valid cycle = WIDTH+1 clocks; minimum spacing between successive gnt pulses = WIDTH+2 clocks.
REQ-022 Overflow SHALL wrap: 0xFF+0x01 gives res_sum 0x00 (WIDTH=8).
REQ-023 req changes during ADD/DONE SHALL have no effect on the in-flight operation; no gnt outside IDLE.
REQ-024 Simultaneous requests SHALL be served in strict round-robin order; no requester waits more than NREQ-1 operations.
REQ-025 res_sum SHALL read zero in IDLE and ADD is not required; res_sum only meaningful while res_valid.

Reset
REQ-026 On rst: state IDLE, gnt 0, busy 0, res_valid 0, res_sum 0, res_id 0, res_cout 0, carry 0, counter 0, last_id NREQ-1 (so requester 0 has first priority).
REQ-027 rst asserted mid-ADD or mid-DONE SHALL abandon the operation with no res_valid and no further gnt until rst deasserts.

Configuration
REQ-028 Macro ADD_SERIAL_SCHED_COUT_EN defined: res_cout port exists and carries final carry, registered with res_sum.
REQ-029 Macro undefined: res_cout port and its register absent; all other behaviour identical.

Structure
REQ-030 Shared package add_sched_pkg SHALL hold the state enumeration (IDLE, ADD, DONE) and default WIDTH/NREQ constants.
REQ-031 Bit-serial datapath (operand shift registers, carry flop, sum shift register, bit counter) SHALL be sub-module serial_add_core, with load/step/last controls driven by the scheduler FSM.

Verification
REQ-032 Only req[0], a=0x35, b=0x4A -> gnt=0001 one cycle, res_valid 9 cycles later, res_sum 0x7F, res_id 0.
REQ-033 req[2], a=0xFF, b=0x01 -> res_sum 0x00; res_cout 1 with macro; port absent without.
REQ-034 All four req held high, res_ready=1 -> gnt order 0,1,2,3,0 with 10-cycle spacing; res_id sequence matches.
REQ-035 res_ready low 5 cycles in DONE -> res_valid/res_sum/res_id stable, busy 1, no gnt; accepted on sixth cycle, IDLE next.
REQ-036 rst pulse at ADD cycle 4 -> all outputs zero, no res_valid; next req[3] alone and req[0..3] together -> requester 0 granted first.
